// File: rtl/alu_issue_unit.sv
// Issue/writeback stage feeding an external combinational ALU; 2 edges from accept to regfile write.
// Backpressure: instr_ready is high only in IDLE, so at most one instruction is accepted every 3 cycles.
module alu_issue_unit #(
    parameter int DATA_WIDTH = 16,
    parameter int REG_COUNT  = 8,
    parameter int REG_ADDR_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [2:0]            instr_op,
    input  logic [REG_ADDR_W-1:0] instr_rd,
    input  logic [REG_ADDR_W-1:0] instr_rs1,
    input  logic [REG_ADDR_W-1:0] instr_rs2,
    input  logic                  instr_use_imm,
    input  logic [DATA_WIDTH-1:0] instr_imm,
    output logic [2:0]            alu_op,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    input  logic [DATA_WIDTH-1:0] alu_f,
    output logic                  wb_valid,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic                  div_zero,
    input  logic [REG_ADDR_W-1:0] dbg_addr,
    output logic [DATA_WIDTH-1:0] dbg_data
);

    localparam logic [2:0] OP_DIV = 3'b011;

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    state_t                  state_q, state_d;
    logic [2:0]              op_q, op_d;
    logic [REG_ADDR_W-1:0]   rd_q, rd_d;
    logic [DATA_WIDTH-1:0]   a_q, a_d;
    logic [DATA_WIDTH-1:0]   b_q, b_d;
    logic [DATA_WIDTH-1:0]   res_q, res_d;
    logic                    dz_q, dz_d;
    logic                    wr_en;
    logic [DATA_WIDTH-1:0]   regs_q [REG_COUNT];
    logic [DATA_WIDTH-1:0]   rs1_val, rs2_val;

    // Register 0 is hardwired to zero on every read path.
    assign rs1_val  = (instr_rs1 == '0) ? '0 : regs_q[instr_rs1];
    assign rs2_val  = (instr_rs2 == '0) ? '0 : regs_q[instr_rs2];
    assign dbg_data = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];

    assign alu_op  = op_q;
    assign alu_a   = a_q;
    assign alu_b   = b_q;
    assign wb_rd   = rd_q;
    assign wb_data = res_q;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        rd_d        = rd_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        dz_d        = dz_q;
        wr_en       = 1'b0;
        instr_ready = 1'b0;
        wb_valid    = 1'b0;
        div_zero    = 1'b0;
        case (state_q)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    op_d    = instr_op;
                    rd_d    = instr_rd;
                    a_d     = rs1_val;
                    b_d     = instr_use_imm ? instr_imm : rs2_val;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                // Divide by zero is resolved here so an undefined ALU result never reaches the regfile.
                if (op_q == OP_DIV && b_q == '0) begin
                    res_d = '1;
                    dz_d  = 1'b1;
                end else begin
                    res_d = alu_f;
                    dz_d  = 1'b0;
                end
                state_d = WB;
            end
            WB: begin
                wb_valid = 1'b1;
                div_zero = dz_q;
                wr_en    = (rd_q != '0);
                dz_d     = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            rd_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            dz_q    <= 1'b0;
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            dz_q    <= dz_d;
            if (wr_en) begin
                regs_q[rd_q] <= res_q;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit: behavioural ALU, writeback scoreboard, register readback.
module tb_alu_issue_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  instr_op;
    logic [2:0]  instr_rd, instr_rs1, instr_rs2;
    logic        instr_use_imm;
    logic [15:0] instr_imm;
    logic [2:0]  alu_op;
    logic [15:0] alu_a, alu_b, alu_f;
    logic        wb_valid;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data;
    logic        div_zero;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    typedef struct {
        logic [2:0]  rd;
        logic [15:0] data;
        logic        dz;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   n_accept = 0;

    always #5 clk = ~clk;

    alu_issue_unit dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1),
        .instr_rs2(instr_rs2), .instr_use_imm(instr_use_imm), .instr_imm(instr_imm),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .div_zero(div_zero),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // External ALU; div-by-zero returns junk so the unit's override is visible.
    always_comb begin
        case (alu_op)
            3'b000:  alu_f = alu_a + alu_b;
            3'b001:  alu_f = alu_a - alu_b;
            3'b010:  alu_f = alu_a * alu_b;
            3'b011:  alu_f = (alu_b == 16'h0) ? 16'h1234 : alu_a / alu_b;
            3'b100:  alu_f = ~alu_a;
            3'b101:  alu_f = alu_a ^ alu_b;
            3'b110:  alu_f = alu_a | alu_b;
            default: alu_f = alu_a & alu_b;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        n_assert++;
        assert (!(div_zero && !wb_valid)) else begin
            n_fail++;
            $error("FAIL div_zero_unqualified observed=1 expected=0");
        end
        if (wb_valid) begin
            n_assert++;
            assert (sb.size() > 0) else begin
                n_fail++;
                $error("FAIL wb_unexpected observed rd=%0d data=%0h expected no writeback", wb_rd, wb_data);
            end
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("wb_rd", 32'(wb_rd), 32'(e.rd));
                chk("wb_data", 32'(wb_data), 32'(e.data));
                chk("div_zero", 32'(div_zero), 32'(e.dz));
            end
        end
        if (instr_valid && instr_ready) n_accept++;
    end

    task automatic check_reg(input logic [2:0] r, input logic [15:0] expv);
        @(negedge clk);
        dbg_addr = r;
        #1;
        chk($sformatf("dbg_r%0d", r), 32'(dbg_data), 32'(expv));
    endtask

    task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic use_imm, input logic [15:0] imm,
                         input logic [15:0] expd, input logic expz);
        int waited;
        exp_t e;
        waited = 0;
        @(negedge clk);
        while (!instr_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("ready_timeout", 32'(instr_ready), 32'd1);
        instr_valid = 1'b1; instr_op = op; instr_rd = rd; instr_rs1 = rs1;
        instr_rs2 = rs2; instr_use_imm = use_imm; instr_imm = imm;
        e.rd = rd; e.data = expd; e.dz = expz;
        sb.push_back(e);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr_op = $urandom_range(7, 0);
        instr_imm = 16'($urandom);
        @(negedge clk);
        chk("exec_ready", 32'(instr_ready), 32'd0);
        chk("exec_alu_op", 32'(alu_op), 32'(op));
        @(negedge clk);
        chk("wb_ready", 32'(instr_ready), 32'd0);
        chk("wb_valid", 32'(wb_valid), 32'd1);
        @(negedge clk);
        chk("idle_ready", 32'(instr_ready), 32'd1);
        chk("idle_wb_valid", 32'(wb_valid), 32'd0);
        chk("wb_data_hold", 32'(wb_data), 32'(expd));
        chk("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        exp_t e;
        int acc0;
        rst = 1'b1; instr_valid = 1'b0; instr_op = 3'd0; instr_rd = 3'd0;
        instr_rs1 = 3'd0; instr_rs2 = 3'd0; instr_use_imm = 1'b0; instr_imm = 16'h0;
        dbg_addr = 3'd0;
        #12;
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_wb_data", 32'(wb_data), 32'd0);
        chk("rst_div_zero", 32'(div_zero), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_alu_b", 32'(alu_b), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_ready", 32'(instr_ready), 32'd1);
        for (int r = 0; r < 8; r++) check_reg(3'(r), 16'h0);

        issue(3'b000, 3'd1, 3'd0, 3'd0, 1'b1, 16'd5, 16'd5, 1'b0);
        check_reg(3'd1, 16'd5);

        issue(3'b000, 3'd2, 3'd0, 3'd0, 1'b1, 16'd3, 16'd3, 1'b0);
        issue(3'b001, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0, 16'd2, 1'b0);
        issue(3'b010, 3'd4, 3'd1, 3'd2, 1'b0, 16'h0, 16'd15, 1'b0);
        issue(3'b001, 3'd5, 3'd2, 3'd1, 1'b0, 16'h0, 16'hFFFE, 1'b0);
        check_reg(3'd3, 16'd2);
        check_reg(3'd4, 16'd15);
        check_reg(3'd5, 16'hFFFE);

        issue(3'b011, 3'd6, 3'd1, 3'd0, 1'b0, 16'h0, 16'hFFFF, 1'b1);
        issue(3'b011, 3'd7, 3'd1, 3'd0, 1'b1, 16'd2, 16'd2, 1'b0);
        check_reg(3'd6, 16'hFFFF);
        check_reg(3'd7, 16'd2);

        issue(3'b100, 3'd1, 3'd1, 3'd3, 1'b0, 16'h0, 16'hFFFA, 1'b0);
        issue(3'b101, 3'd5, 3'd4, 3'd0, 1'b1, 16'h00FF, 16'h00F0, 1'b0);
        issue(3'b110, 3'd6, 3'd4, 3'd0, 1'b1, 16'h00FF, 16'h00FF, 1'b0);
        issue(3'b111, 3'd7, 3'd4, 3'd0, 1'b1, 16'h00FF, 16'h000F, 1'b0);
        check_reg(3'd1, 16'hFFFA);
        check_reg(3'd7, 16'h000F);

        issue(3'b000, 3'd0, 3'd0, 3'd0, 1'b1, 16'd9, 16'd9, 1'b0);
        check_reg(3'd0, 16'h0);

        // Continuous valid for 9 edges must yield exactly three accepts.
        @(negedge clk);
        acc0 = n_accept;
        e.rd = 3'd2; e.data = 16'd1; e.dz = 1'b0;
        repeat (3) sb.push_back(e);
        @(posedge clk);
        #1;
        instr_valid = 1'b1; instr_op = 3'b000; instr_rd = 3'd2; instr_rs1 = 3'd0;
        instr_use_imm = 1'b1; instr_imm = 16'd1;
        repeat (9) @(posedge clk);
        #1;
        instr_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("stream_accepts", 32'(n_accept - acc0), 32'd3);
        chk("stream_sb_drained", 32'(sb.size()), 32'd0);
        check_reg(3'd2, 16'd1);

        // Reset during EXEC discards the instruction and clears the regfile.
        @(negedge clk);
        instr_valid = 1'b1; instr_op = 3'b000; instr_rd = 3'd2; instr_rs1 = 3'd0;
        instr_use_imm = 1'b1; instr_imm = 16'd7;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        chk("pre_rst_in_exec", 32'(instr_ready), 32'd0);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_async_wb_valid", 32'(wb_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_release_ready", 32'(instr_ready), 32'd1);
        for (int r = 0; r < 8; r++) check_reg(3'(r), 16'h0);
        repeat (3) @(negedge clk);
        chk("rst_no_pending", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_issue_unit.md
Name: alu_issue_unit

Overview:
- Sequential issue/writeback stage wrapped around the combinational ALU of the sim CPU.
- Accepts one decoded instruction at a time over a valid/ready handshake and reads operands from an internal register file. Drives the ALU's op/a/b inputs from latched registers, captures the ALU result and writes it back.
- Sits between the decoder (upstream) and the ALU. The ALU itself stays external; this block only feeds it and consumes its result.

Parameters:
DATA_WIDTH, 16, width of operands, immediates, registers and ALU result.
REG_COUNT, 8, number of architectural registers.
REG_ADDR_W, 3, register index width; must equal clog2(REG_COUNT).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
instr_valid  input  1  decoder presents an instruction.
instr_ready  output  1  unit can accept an instruction this cycle.
instr_op  input  3  ALU opcode: 000 add, 001 sub, 010 mul, 011 div, 100 not, 101 xor, 110 or, 111 and.
instr_rd  input  REG_ADDR_W  destination register.
instr_rs1  input  REG_ADDR_W  source register for ALU a.
instr_rs2  input  REG_ADDR_W  source register for ALU b; ignored when instr_use_imm=1.
instr_use_imm  input  1  1: ALU b = instr_imm.
instr_imm  input  DATA_WIDTH  immediate operand.
alu_op  output  3  to ALU in.
alu_a  output  DATA_WIDTH  to ALU a.
alu_b  output  DATA_WIDTH  to ALU b.
alu_f  input  DATA_WIDTH  ALU result, combinational from alu_op/a/b.
wb_valid  output  1  one-cycle pulse: writeback occurring this cycle.
wb_rd  output  REG_ADDR_W  destination of current writeback.
wb_data  output  DATA_WIDTH  value being written.
div_zero  output  1  one-cycle pulse, coincident with wb_valid, when a div had b==0.
dbg_addr  input  REG_ADDR_W  bench register-file read address.
dbg_data  output  DATA_WIDTH  combinational regfile[dbg_addr]; reads 0 for address 0.

Behaviour:
- FSM with three states: IDLE, EXEC, WB. It returns to IDLE on rst, asynchronously.
- Reset values: all registers in the file are 0, state is IDLE, and alu_op/alu_a/alu_b are 0. wb_valid=0, wb_rd=0, wb_data=0, div_zero=0. instr_ready=1 after reset deasserts.
- Register 0 reads as 0 and ignores writes. wb_valid still pulses for rd=0.
- IDLE:
  - instr_ready=1.
  - On instr_valid at a rising edge, latch the following and go to EXEC:
    - op_q=instr_op and rd_q=instr_rd.
    - a_q=reg[rs1].
    - b_q = instr_use_imm ? instr_imm : reg[rs2].
  - With no instr_valid, stay in IDLE.
- EXEC:
  - instr_ready=0. alu_op/alu_a/alu_b equal op_q/a_q/b_q (registered, stable for the whole state).
  - At the next edge, res_q = alu_f, except when op_q==011 and b_q==0: then res_q = all-ones and dz_q=1.
  - Go to WB.
- WB:
  - instr_ready=0. wb_valid=1, wb_rd=rd_q, wb_data=res_q, div_zero=dz_q.
  - At the edge, reg[rd_q]=res_q (unless rd_q==0), clear dz_q, and go to IDLE.
- Timing:
  - Throughput: one instruction per 3 cycles.
  - Latency: from the accepting edge to the regfile write is 2 edges.
  - An instruction accepted in the IDLE cycle right after WB sees the written value; no forwarding is needed.
- Arithmetic: all results truncate to DATA_WIDTH.
  - Mul keeps the low DATA_WIDTH bits.
  - Not ignores b.
  - The unit never exposes an x result on div-by-zero.
- wb_* outputs hold their last values outside WB; only wb_valid and div_zero are qualified.
- instr_* inputs may change freely while instr_ready=0 and are ignored.
- Reset asserted in EXEC or WB: the in-flight instruction is discarded with no writeback and the regfile clears. wb_valid drops immediately (asynchronously).
- rd==rs1 or rd==rs2 is legal: operands are latched before the write.

Test Plan:
- Reset, then issue add r1=r0+imm 5 (rs1=0, use_imm=1, imm=5) → instr_ready low for 2 cycles, wb_valid pulse with wb_rd=1 and wb_data=5, dbg_data(1)=5.
- Using r1=5, issue add r2=r0+imm 3, then sub r3=r1-r2 and mul r4=r1*r2 → r3=2, r4=15. Then sub r5=r2-r1 → 16'hFFFE (wrap).
- Issue div r6=r1/r0 (b=0) → wb_data=16'hFFFF and div_zero=1 in the same cycle as wb_valid. Then div r7=r1/imm 2 → 2, div_zero=0.
- Issue not r1=~r1 and xor/or/and with imm 16'h00FF on r4=15 → 16'hFFFA, 16'h00F0, 16'h00FF, 16'h000F.
- Write to r0 (add r0=r0+imm 9) → wb_valid pulses, dbg_data(0) stays 0. Holding instr_valid high continuously → exactly one accept per 3 cycles.
- Assert rst during EXEC of add r2=r0+imm 7 → no wb_valid, all registers read 0, instr_ready=1 after release.
